div_fpga: RTL and testbench
===========================

DIV_FPGA -- requirements
Module: div_fpga

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive high samples of start that count as a press; used only when DIV_FPGA_DEBOUNCE_EN is defined.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port s, input, 4, operand-pair select lines.
REQ-005 SHALL have port start, input, 1, board push-button that launches a division.
REQ-006 SHALL have port button, input, 1, display select: 0 = quotient[3:0], 1 = quotient[7:4].
REQ-007 SHALL have port out, output, 4, selected quotient nibble.
REQ-008 SHALL have port rem, output, 4, remainder.
REQ-009 SHALL have port busy, output, 1, high while iterating.
REQ-010 SHALL have port done, output, 1, high while results are valid.
REQ-011 SHALL have port err, output, 1, divide-by-zero flag.

Function
REQ-012 SHALL decode s to an 8-bit dividend and 4-bit divisor, inverting the team's multiplier table.
- 0000: 2/1
- 0001: 12/3
- 0010: 30/5
- 0011: 56/7
- 0100: 90/9
- 0101: 132/11
- 0110: 182/13
- 0111: 0/15
- s[3]=1: 0/0
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL accept a start at an edge E when the FSM is in IDLE or DONE and the press is rising: start sampled 1 at E and 0 at E-1 (raw or debounced, per Configuration).
REQ-015 SHALL, at acceptance edge E with divisor != 0, latch the dividend and divisor and clear the 5-bit partial remainder and 4-bit counter. At E: busy=1, done=0, err=0, state=CALC.
REQ-016 SHALL, at edges E+1..E+8, perform one restoring shift-subtract step per edge, MSB of the dividend first.
- Shift the partial remainder left by one and bring in the next dividend bit.
- If the result is >= divisor, subtract the divisor and shift a 1 into the quotient; otherwise shift in a 0.
REQ-017 SHALL, at edge E+8, enter DONE with busy=0, done=1, quotient and rem final. Latency is 8 cycles from acceptance.
REQ-018 SHALL, at acceptance with divisor == 0, enter DONE directly at E with quotient=8'hFF, rem=0, err=1, busy=0, done=1.
REQ-019 SHALL ignore start while in CALC, and SHALL ignore changes on s after acceptance.
REQ-020 SHALL hold quotient, rem, err and done in DONE until the next accepted start.
REQ-021 SHALL drive out combinationally from the quotient register according to button; a button change is reflected in the same cycle.
REQ-022 SHALL guarantee rem < divisor for divisor != 0, so rem always fits in 4 bits.

Reset
REQ-023 SHALL, on an rst-high edge, set state=IDLE, quotient=0, out=0, rem=0, busy=0, done=0, err=0, counter=0, start history=0 and debounce counter=0.
REQ-024 SHALL abort any in-progress division on rst; the first accept after rst deasserts needs a fresh rising press.
REQ-025 SHALL give rst priority over a simultaneous start.

Configuration
REQ-026 SHALL use macro DIV_FPGA_DEBOUNCE_EN to select how start is conditioned.
- Defined: start passes through a 2-flop synchronizer; the debounced level rises only after DEBOUNCE_CYCLES consecutive high synchronized samples and falls on the first low sample. Acceptance uses the rising edge of the debounced level, which adds 2+DEBOUNCE_CYCLES cycles before E.
- Undefined: start is registered once and its raw rising edge is used; no synchronizer, no counter, DEBOUNCE_CYCLES unused.

Verification
REQ-027 SHALL cover: s=0011, start pulse -> busy for 8 cycles, then done=1, out=8 (button=0), out=0 (button=1), rem=0, err=0.
REQ-028 SHALL cover: s=0101, start -> done after 8 cycles, quotient=0x0C, out=C (button=0), rem=0; then s=0110, start -> quotient=0x0E.
REQ-029 SHALL cover: s=1000, start -> done=1 and err=1 at the acceptance edge, out=F for both button values, rem=0.
REQ-030 SHALL cover: s=0100, start, then start re-pulsed and s changed to 0000 during CALC -> both ignored, quotient=0x0A.
REQ-031 SHALL cover: rst asserted at cycle 4 of CALC -> next edge busy=0, done=0, out=0; a new start runs normally.
REQ-032 SHALL cover, with DIV_FPGA_DEBOUNCE_EN defined and DEBOUNCE_CYCLES=16: a 10-cycle start glitch is rejected; a 20-cycle press is accepted exactly once.

Source files
------------

// File: rtl/div_fpga.sv
// div_fpga: 8-bit by 4-bit restoring divider driven from board switches.
// s selects a dividend/divisor pair. A rising press on start launches a
// division, which takes 8 cycles, or finishes at once for a zero divisor.
// button picks which quotient nibble appears on out.
// Build option: define DIV_FPGA_DEBOUNCE_EN to pass start through a
// synchronizer and a DEBOUNCE_CYCLES debouncer. By default start is
// registered once and only its raw rising edge is used.
//
// state | meaning
// IDLE  | after reset, no result yet
// CALC  | shift-subtract iterations in progress (busy)
// DONE  | quotient/rem/err valid and held (done)
module div_fpga #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] s,
  input  logic       start,
  input  logic       button,
  output logic [3:0] out,
  output logic [3:0] rem,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic [3:0] prem;
  logic [3:0] cnt;
  logic [7:0] quo;
  logic       errq;
  logic       start_q;
  logic       press;
  logic       accept;

  logic [7:0] dec_dvd;
  logic [3:0] dec_dvs;
  logic [4:0] trial;
  logic [3:0] diff;
  logic       step_bit;
  logic [3:0] step_prem;

  // Operand table: each pair is the inverse of a multiplier table entry.
  always_comb begin
    dec_dvd = 8'd0;
    dec_dvs = 4'd0;
    if (!s[3]) begin
      case (s[2:0])
        3'd0: begin dec_dvd = 8'd2;   dec_dvs = 4'd1;  end
        3'd1: begin dec_dvd = 8'd12;  dec_dvs = 4'd3;  end
        3'd2: begin dec_dvd = 8'd30;  dec_dvs = 4'd5;  end
        3'd3: begin dec_dvd = 8'd56;  dec_dvs = 4'd7;  end
        3'd4: begin dec_dvd = 8'd90;  dec_dvs = 4'd9;  end
        3'd5: begin dec_dvd = 8'd132; dec_dvs = 4'd11; end
        3'd6: begin dec_dvd = 8'd182; dec_dvs = 4'd13; end
        default: begin dec_dvd = 8'd0; dec_dvs = 4'd15; end
      endcase
    end
  end

`ifdef DIV_FPGA_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic           sync1, sync2, deb;
  logic [DBW-1:0] dbc;

  // Synchronize start, then require DEBOUNCE_CYCLES high samples in a row.
  // The level drops on the first low sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      dbc     <= '0;
      start_q <= 1'b0;
    end else begin
      sync1   <= start;
      sync2   <= sync1;
      start_q <= deb;
      if (!sync2) begin
        dbc <= '0;
        deb <= 1'b0;
      end else if (dbc == DBW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= 1'b1;
      end else begin
        dbc <= dbc + 1'b1;
      end
    end
  end

  assign press = deb & ~start_q;
`else
  // Remember the previous start sample so that only a rising press counts.
  always_ff @(posedge clk) begin
    if (rst) start_q <= 1'b0;
    else     start_q <= start;
  end

  assign press = start & ~start_q;
`endif

  // One restoring step: shift in the next dividend bit, then subtract if it fits.
  // The partial remainder stays below the divisor, so the difference fits in 4 bits.
  always_comb begin
    trial     = {prem, dvd[7]};
    step_bit  = (trial >= {1'b0, dvs});
    diff      = trial[3:0] - dvs;
    step_prem = step_bit ? diff : trial[3:0];
  end

  // Next state. A press is accepted only outside CALC.
  always_comb begin
    state_nx = state;
    accept   = press && (state != CALC);
    case (state)
      IDLE, DONE: if (accept) state_nx = (dec_dvs == 4'd0) ? DONE : CALC;
      CALC:       if (cnt == 4'd7) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath: latch the operands when a press is accepted, then iterate once per cycle in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd  <= 8'd0;
      dvs  <= 4'd0;
      prem <= 4'd0;
      cnt  <= 4'd0;
      quo  <= 8'd0;
      errq <= 1'b0;
    end else if (accept) begin
      prem <= 4'd0;
      cnt  <= 4'd0;
      if (dec_dvs == 4'd0) begin
        quo  <= 8'hFF;
        errq <= 1'b1;
      end else begin
        dvd  <= dec_dvd;
        dvs  <= dec_dvs;
        quo  <= 8'd0;
        errq <= 1'b0;
      end
    end else if (state == CALC) begin
      prem <= step_prem;
      quo  <= {quo[6:0], step_bit};
      dvd  <= {dvd[6:0], 1'b0};
      cnt  <= cnt + 4'd1;
    end
  end

  // Outputs are decoded from the state and registers; out follows button without waiting for a clock.
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
    err  = errq;
    rem  = prem;
    out  = button ? quo[7:4] : quo[3:0];
  end

endmodule

// File: tb/tb_div_fpga.sv
// tb_div_fpga: scoreboard bench for div_fpga. The stimulus pushes the
// expected result of every accepted press. The monitor pops an entry when
// done rises, then checks out, rem and err for as long as done stays high.
module tb_div_fpga;

  logic       clk = 1'b0;
  logic       rst, start, button;
  logic [3:0] s;
  logic [3:0] out, rem;
  logic       busy, done, err;

  always #5 clk = ~clk;

  div_fpga dut (
    .clk(clk), .rst(rst), .s(s), .start(start), .button(button),
    .out(out), .rem(rem), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on every new done, then check the held results.
  exp_t cur;
  bit   have   = 1'b0;
  logic done_p = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1 && done_p !== 1'b1) begin
      n_rise++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        have = 1'b0;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result pending", cyc);
      end else begin
        cur  = sbq.pop_front();
        have = 1'b1;
        if (cur.cyc >= 0) chk("done_latency", cyc, cur.cyc);
      end
    end
    if (done !== 1'b1) have = 1'b0;
    if (have) begin
      chk("out", {28'd0, out}, button ? {28'd0, cur.q[7:4]} : {28'd0, cur.q[3:0]});
      chk("rem", {28'd0, rem}, {28'd0, cur.r});
      chk("err", {31'd0, err}, {31'd0, cur.e});
      chk("busy_in_done", {31'd0, busy}, 32'd0);
    end
    done_p = done;
  end

  task automatic push(input logic [7:0] q, input logic e, input int c);
    exp_t x;
    x.q = q; x.r = 4'd0; x.e = e; x.cyc = c;
    sbq.push_back(x);
  endtask

  // Wait for done, counting busy cycles. Returns whether done arrived.
  task automatic wait_done(input int limit, output int nb, output bit got);
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy === 1'b1) nb++;
      tick();
    end
  endtask

  task automatic sweep_button;
    tick(); button = 1'b1;
    tick(); tick(); button = 1'b0;
    tick();
  endtask

  task automatic run(input logic [3:0] sv, input logic [7:0] q, input int lat);
    int nb;
    bit got;
    tick();
    s = sv; start = 1'b1;
    push(q, (lat == 0), cyc + 1 + lat);
    tick();
    start = 1'b0;
    wait_done(30, nb, got);
    chk("done_timeout", {31'd0, got}, 32'd1);
    chk("busy_cycles", nb, lat);
    sweep_button();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit got;
    rst = 1'b1; start = 1'b0; button = 1'b0; s = 4'd0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    chk("rst_out",  {28'd0, out},  32'd0);
    chk("rst_rem",  {28'd0, rem},  32'd0);
    button = 1'b1; #1;
    chk("rst_out_hi", {28'd0, out}, 32'd0);
    button = 1'b0;
    rst = 1'b0;

`ifdef DIV_FPGA_DEBOUNCE_EN
    // A 10-cycle glitch must not launch anything.
    tick();
    s = 4'b0011; start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    wait_done(40, nb, got);
    chk("glitch_done", {31'd0, got}, 32'd0);
    chk("glitch_busy", nb, 0);
    // A 20-cycle press must launch exactly one division.
    push(8'h08, 1'b0, -1);
    start = 1'b1;
    repeat (20) tick();
    start = 1'b0;
    wait_done(60, nb, got);
    chk("press_done", {31'd0, got}, 32'd1);
    sweep_button();
    repeat (40) tick();
    chk("accept_count", n_rise, 1);
`else
    // Zero divisor from IDLE finishes on the acceptance edge.
    run(4'b1000, 8'hFF, 0);
    run(4'b0011, 8'h08, 8);
    run(4'b0101, 8'h0C, 8);
    run(4'b0110, 8'h0E, 8);
    run(4'b0000, 8'h02, 8);
    run(4'b0111, 8'h00, 8);

    // Re-press and change s during CALC; both must be ignored.
    tick();
    s = 4'b0100; start = 1'b1;
    push(8'h0A, 1'b0, cyc + 9);
    tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; s = 4'b0000;
    tick(); start = 1'b0;
    wait_done(30, nb, got);
    chk("ignore_timeout", {31'd0, got}, 32'd1);
    sweep_button();

    // Reset during the fourth CALC cycle aborts the division.
    tick();
    s = 4'b0011; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_out",  {28'd0, out},  32'd0);
    rst = 1'b0;
    run(4'b0011, 8'h08, 8);

    // A start arriving together with reset loses to the reset.
    tick();
    s = 4'b0101; start = 1'b1; rst = 1'b1;
    tick();
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    chk("rst_prio_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_prio_idle", {31'd0, busy}, 32'd0);
    run(4'b0101, 8'h0C, 8);
`endif

    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
